// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU core: opcodes, FSM states,
// error-priority encoding, CRC polynomials, frame geometry and gap lengths.
package mtm_alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      SEND,
      HOLD
   } state_t;

   // One-hot {err_data, err_crc, err_op}, exactly as the flags appear in ectl
   typedef enum logic [2:0] {
      ERR_NONE = 3'b000,
      ERR_OP   = 3'b001,
      ERR_CRC  = 3'b010,
      ERR_DATA = 3'b100
   } err_t;

   localparam logic [3:0] CRC4_POLY = 4'b0011;
   localparam logic [2:0] CRC3_POLY = 3'b011;
   localparam int         CRC4_LEN  = 68;
   localparam int         CRC3_LEN  = 37;

   localparam int PKT_W   = 11;
   localparam int FRAME_W = 55;

   localparam logic [5:0] GAP_DATA = 6'd58;
   localparam logic [5:0] GAP_ERR  = 6'd14;

   function automatic err_t err_select(input logic ed, input logic ec, input logic eo);
      if (ed)      return ERR_DATA;
      else if (ec) return ERR_CRC;
      else if (eo) return ERR_OP;
      else         return ERR_NONE;
   endfunction

endpackage

// File: rtl/mtm_alu_crc.sv
// Combinational CRC4 checker (input packet) and CRC3 generator (result packet).
// The CRC4 check exists only when MTM_ALU_CRC_CHECK_EN is defined.
module mtm_alu_crc
   import mtm_alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   input  logic [3:0]  crc_rx,
   input  logic [31:0] c,
   input  logic        cf,
   input  logic        vf,
   input  logic        z,
   input  logic        n,
   output logic        crc_err,
   output logic [2:0]  crc3
);

   function automatic logic [2:0] crc3_calc(input logic [CRC3_LEN-1:0] d);
      logic [2:0] r;
      r = '0;
      for (int i = CRC3_LEN - 1; i >= 0; i--)
         r = {r[1:0], 1'b0} ^ ((r[2] ^ d[i]) ? CRC3_POLY : 3'b000);
      return r;
   endfunction

`ifdef MTM_ALU_CRC_CHECK_EN
   function automatic logic [3:0] crc4_calc(input logic [CRC4_LEN-1:0] d);
      logic [3:0] r;
      r = '0;
      for (int i = CRC4_LEN - 1; i >= 0; i--)
         r = {r[2:0], 1'b0} ^ ((r[3] ^ d[i]) ? CRC4_POLY : 4'b0000);
      return r;
   endfunction

   assign crc_err = (crc4_calc({b, a, 1'b1, op}) != crc_rx);
`else
   logic unused_crc4_inputs;
   assign unused_crc4_inputs = ^{a, b, op, crc_rx};
   assign crc_err = 1'b0;
`endif

   assign crc3 = crc3_calc({c, 1'b0, cf, vf, z, n});

endmodule

// File: rtl/mtm_alu_core.sv
// MTM ALU core: captures an operand set, computes C = B op A with flags and CRCs,
// and presents a 55-bit data/error frame. Option: MTM_ALU_CRC_CHECK_EN enables CRC4 checking.
module mtm_alu_core
   import mtm_alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [31:0]        in_a,
   input  logic [31:0]        in_b,
   input  logic [2:0]         in_op,
   input  logic [3:0]         in_crc,
   input  logic               in_err_data,
   output logic               in_ready,
   output logic [FRAME_W-1:0] aluin,
   output logic               dataready
);

   state_t             state_reg, state_next;
   logic [31:0]        a_reg, b_reg;
   logic [2:0]         op_reg;
   logic [3:0]         crc_reg;
   logic               err_data_reg;
   logic [FRAME_W-1:0] aluin_reg, frame_next, data_frame, err_frame;
   logic [5:0]         gap_reg;

   logic [32:0] wide;
   logic [31:0] c;
   logic        cf, vf, z, n, op_valid, err_crc;
   logic [2:0]  crc3;
   logic [7:0]  ctl, ectl;
   err_t        err;

   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         a_reg        <= in_a;
         b_reg        <= in_b;
         op_reg       <= in_op;
         crc_reg      <= in_crc;
         err_data_reg <= in_err_data;
      end
   end

   always_comb begin
      wide = '0;
      c    = '0;
      cf   = 1'b0;
      vf   = 1'b0;
      case (op_reg)
         OP_AND: c = b_reg & a_reg;
         OP_OR:  c = b_reg | a_reg;
         OP_ADD: begin
            wide = {1'b0, b_reg} + {1'b0, a_reg};
            c    = wide[31:0];
            cf   = wide[32];
            vf   = (a_reg[31] == b_reg[31]) && (c[31] != b_reg[31]);
         end
         OP_SUB: begin
            wide = {1'b0, b_reg} - {1'b0, a_reg};
            c    = wide[31:0];
            cf   = wide[32];
            vf   = (a_reg[31] != b_reg[31]) && (c[31] != b_reg[31]);
         end
         default: ;
      endcase
   end

   assign z        = (c == 32'd0);
   assign n        = c[31];
   assign op_valid = (op_reg == OP_AND) || (op_reg == OP_OR) ||
                     (op_reg == OP_ADD) || (op_reg == OP_SUB);

   mtm_alu_crc u_crc (
      .a       (a_reg),
      .b       (b_reg),
      .op      (op_reg),
      .crc_rx  (crc_reg),
      .c       (c),
      .cf      (cf),
      .vf      (vf),
      .z       (z),
      .n       (n),
      .crc_err (err_crc),
      .crc3    (crc3)
   );

   assign err  = err_select(err_data_reg, err_crc, !op_valid);
   assign ctl  = {1'b0, cf, vf, z, n, crc3};
   assign ectl = {1'b1, err, err, ^{1'b1, err, err}};

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte_pkt
      assign data_frame[PKT_W*(gi+1) +: PKT_W] = {2'b00, c[8*gi +: 8], 1'b1};
   end
   assign data_frame[PKT_W-1:0] = {2'b01, ctl, 1'b1};
   assign err_frame  = {{(FRAME_W-PKT_W){1'b0}}, 2'b01, ectl, 1'b1};
   assign frame_next = (err != ERR_NONE) ? err_frame : data_frame;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         aluin_reg <= '0;
         gap_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == EXEC)
            aluin_reg <= frame_next;
         // The dataready cycle counts as the first gap cycle, so the count hits 0 on the edge back to IDLE
         if (state_reg == SEND)
            gap_reg <= (aluin_reg[8] ? GAP_ERR : GAP_DATA) - 6'd1;
         else if (gap_reg != 6'd0)
            gap_reg <= gap_reg - 6'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = EXEC;
         EXEC:    state_next = SEND;
         SEND:    state_next = HOLD;
         HOLD:    if (gap_reg <= 6'd1) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign dataready = (state_reg == SEND);
   assign aluin     = aluin_reg;

endmodule

// File: tb/tb_mtm_alu_core.sv
// Self-checking bench for mtm_alu_core: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_mtm_alu_core;

`ifdef MTM_ALU_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [2:0]  in_op = '0;
   logic [3:0]  in_crc = '0;
   logic        in_err_data = 1'b0;
   logic        in_ready;
   logic [54:0] aluin;
   logic        dataready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mtm_alu_core dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_op       (in_op),
      .in_crc      (in_crc),
      .in_err_data (in_err_data),
      .in_ready    (in_ready),
      .aluin       (aluin),
      .dataready   (dataready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // CRC as remainder of polynomial division of message * x^deg by the generator
   function automatic logic [3:0] crc4_ref(input logic [67:0] d);
      logic [71:0] m;
      m = {d, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
      return m[3:0];
   endfunction

   function automatic logic [2:0] crc3_ref(input logic [36:0] d);
      logic [39:0] m;
      m = {d, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
      return m[2:0];
   endfunction

   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [3:0] crc, input logic ed,
                        output logic [54:0] f, output int gap);
      longint sa, sb, sr;
      logic [32:0] sum;
      logic [31:0] c;
      logic cf, vf, z, n, eo, ec;
      logic [2:0] e;
      logic [7:0] ectl;
      sa = $signed(a);
      sb = $signed(b);
      sr = 0;
      c = '0; cf = 0; vf = 0;
      eo = !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
      ec = CRC_EN && (crc4_ref({b, a, 1'b1, op}) != crc);
      case (op)
         3'b000: c = b & a;
         3'b001: c = b | a;
         3'b100: begin
            sum = 33'(b) + 33'(a);
            c = sum[31:0];
            cf = sum[32];
            sr = sb + sa;
         end
         3'b101: begin
            c = b - a;
            cf = (b < a);
            sr = sb - sa;
         end
         default: ;
      endcase
      vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (c == 0);
      n = c[31];
      if (ed || ec || eo) begin
         e = ed ? 3'b100 : (ec ? 3'b010 : 3'b001);
         ectl[7:1] = {1'b1, e, e};
         ectl[0] = ^ectl[7:1];
         f = {44'd0, 2'b01, ectl, 1'b1};
         gap = 14;
      end else begin
         f = {2'b00, c[31:24], 1'b1, 2'b00, c[23:16], 1'b1, 2'b00, c[15:8], 1'b1,
              2'b00, c[7:0], 1'b1, 2'b01, 1'b0, cf, vf, z, n,
              crc3_ref({c, 1'b0, cf, vf, z, n}), 1'b1};
         gap = 58;
      end
   endtask

   // Called at a negedge with in_ready=1; returns at the negedge where in_ready is 1 again
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [3:0] crc, input logic ed,
                         input bit poke);
      logic [54:0] exp_f, held;
      int exp_gap, cnt, strays;
      model(a, b, op, crc, ed, exp_f, exp_gap);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_crc = crc; in_err_data = ed;
      @(negedge clk);
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
      check({tag, "_ready_in_exec"}, in_ready, 1'b0);
      check({tag, "_dataready_n1"}, dataready, 1'b0);
      @(negedge clk);
      check({tag, "_dataready_n2"}, dataready, 1'b1);
      check({tag, "_frame"}, aluin, exp_f);
      held = aluin;
      cnt = 0;
      strays = 0;
      do begin
         in_valid = (poke && cnt == 3);
         in_err_data = $urandom_range(0, 1);
         @(negedge clk);
         cnt++;
         if (dataready) strays++;
      end while (!in_ready && cnt < 100);
      in_valid = 1'b0;
      in_err_data = 1'b0;
      check({tag, "_gap"}, cnt, exp_gap);
      check({tag, "_no_extra_dataready"}, strays, 0);
      check({tag, "_frame_held"}, aluin, held);
      $display("txn %s a=%h b=%h op=%b crc=%h ed=%b poke=%0d frame=%h gap=%0d",
               tag, a, b, op, crc, ed, poke, aluin, cnt);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      logic [3:0]  rcrc;
      logic        red;
      int          strays;
      logic [31:0] edge_vals [4];
      edge_vals[0] = 32'h0000_0000;
      edge_vals[1] = 32'hFFFF_FFFF;
      edge_vals[2] = 32'h7FFF_FFFF;
      edge_vals[3] = 32'h8000_0000;

      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_dataready", dataready, 1'b0);
      check("reset_aluin", aluin, 55'd0);

      run_op("add_1_2", 32'd1, 32'd2, 3'b100, crc4_ref({32'd2, 32'd1, 1'b1, 3'b100}), 1'b0, 1'b0);
      check("add_1_2_bytes", aluin[54:11], {11'h001, 11'h001, 11'h001, 11'h007});
      check("add_1_2_ctl_flags", aluin[8:4], 5'b00000);

      run_op("sub_0_1", 32'd1, 32'd0, 3'b101, crc4_ref({32'd0, 32'd1, 1'b1, 3'b101}), 1'b0, 1'b0);
      check("sub_0_1_bytes", aluin[54:11], {11'h1FF, 11'h1FF, 11'h1FF, 11'h1FF});
      check("sub_0_1_flags", aluin[8:4], 5'b01001);

      run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'b100,
             crc4_ref({32'd1, 32'h7FFF_FFFF, 1'b1, 3'b100}), 1'b0, 1'b0);
      check("add_ovf_bytes", aluin[54:11], {11'h101, 11'h001, 11'h001, 11'h001});
      check("add_ovf_flags", aluin[8:4], 5'b00101);

      run_op("bad_op", 32'h1234_5678, 32'h9ABC_DEF0, 3'b010,
             crc4_ref({32'h9ABC_DEF0, 32'h1234_5678, 1'b1, 3'b010}), 1'b0, 1'b1);
      check("bad_op_ectl", aluin[8:1], 8'b1001_0011);
      check("bad_op_upper_zero", aluin[54:11], 44'd0);

      run_op("ed_badcrc", 32'd5, 32'd6, 3'b000,
             crc4_ref({32'd6, 32'd5, 1'b1, 3'b000}) ^ 4'b0101, 1'b1, 1'b1);
      check("ed_badcrc_ectl", aluin[8:1], 8'b1100_1001);

      run_op("badcrc", 32'hF0F0_1111, 32'h0FF0_3333, 3'b001,
             crc4_ref({32'h0FF0_3333, 32'hF0F0_1111, 1'b1, 3'b001}) ^ 4'b1000, 1'b0, 1'b0);
`ifdef MTM_ALU_CRC_CHECK_EN
      check("badcrc_ectl", aluin[8:1], 8'b1010_0101);
`else
      check("badcrc_data_frame", aluin[8], 1'b0);
`endif

      // Reset during EXEC aborts the operation
      in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4; in_op = 3'b100;
      in_crc = crc4_ref({32'd4, 32'd3, 1'b1, 3'b100});
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rst_exec_in_ready", in_ready, 1'b1);
      check("rst_exec_aluin", aluin, 55'd0);
      strays = 0;
      repeat (5) begin
         @(negedge clk);
         if (dataready) strays++;
      end
      check("rst_exec_no_dataready", strays, 0);

      // Reset during HOLD
      in_valid = 1'b1; in_a = 32'd10; in_b = 32'd20; in_op = 3'b101;
      in_crc = crc4_ref({32'd20, 32'd10, 1'b1, 3'b101});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_hold_dataready", dataready, 1'b1);
      repeat (5) @(negedge clk);
      check("rst_hold_busy", in_ready, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_hold_in_ready", in_ready, 1'b1);
      check("rst_hold_aluin", aluin, 55'd0);
      rst = 1'b1;
      strays = 0;
      repeat (70) begin
         @(negedge clk);
         if (dataready) strays++;
      end
      check("rst_hold_no_dataready", strays, 0);
      check("rst_hold_idle", in_ready, 1'b1);

      for (int i = 0; i < 30; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         case ($urandom_range(0, 4))
            0:       rop = 3'b000;
            1:       rop = 3'b001;
            2:       rop = 3'b100;
            3:       rop = 3'b101;
            default: rop = 3'($urandom);
         endcase
         rcrc = crc4_ref({rb, ra, 1'b1, rop});
         if ($urandom_range(0, 6) == 0) rcrc = rcrc ^ 4'($urandom_range(1, 15));
         red = ($urandom_range(0, 9) == 0);
         run_op($sformatf("rnd%0d", i), ra, rb, rop, rcrc, red, $urandom_range(0, 4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
